rx_timer: RTL and testbench
===========================

# rx_timer

Bit-period timer for the UART receive path. It sits directly downstream of the receiver control unit and consumes its `enable_timer` output. While enabled, it produces one `shift_strobe` per serial bit period to clock the receive shift register. After the configured number of bits it raises `packet_done` back to the control unit, which ends the data-read phase.

## Interface
- `CLKS_PER_BIT`, default 10: clock cycles per serial bit period; must be at least 2.
- `SAMPLE_POINT`, default 10: value of the in-period count at which the strobe fires; legal range 1..`CLKS_PER_BIT`.
- `NUM_BITS`, default 9: strobes per packet (8 data bits plus 1 stop bit); must be at least 1.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `enable_timer`  in  1  held high by the control unit for the whole data-read phase.
- `shift_strobe`  out  1  one-cycle pulse; the shift register samples serial data in this cycle.
- `packet_done`  out  1  high once all `NUM_BITS` strobes have been issued.
- `bit_count`  out  $clog2(`NUM_BITS`+1)  number of strobes issued so far in the current packet.

## Operation
- There are two registered counters:
  - `clk_cnt`, range 0..`CLKS_PER_BIT`, width $clog2(`CLKS_PER_BIT`+1).
  - `bit_cnt`, range 0..`NUM_BITS`, drives `bit_count`.
- `clk_cnt` next-state rules, in priority order:
  - `rst` = 1 → 0.
  - `enable_timer` = 0 → 0.
  - `clk_cnt` == `CLKS_PER_BIT` → 1 (wrap).
  - otherwise → `clk_cnt` + 1.
- `shift_strobe` = `enable_timer` && (`clk_cnt` == `SAMPLE_POINT`) && (`bit_cnt` < `NUM_BITS`). It is a decode of registered state, gated by the enable.
- `bit_cnt` next-state rules, in priority order:
  - `rst` = 1 → 0.
  - `enable_timer` = 0 → 0.
  - `shift_strobe` = 1 → `bit_cnt` + 1.
  - otherwise → hold.
- `bit_cnt` saturates at `NUM_BITS`; no strobe is issued once it is reached.
- `packet_done` = `enable_timer` && (`bit_cnt` == `NUM_BITS`). It is a level: it stays high until the enable drops.
- `clk_cnt` keeps wrapping after `packet_done`. This is harmless because strobes are suppressed.
- All arithmetic is unsigned. Counter widths are exact, so no overflow is possible within the legal ranges.

## Timing
- Reset values: `clk_cnt` = 0 and `bit_cnt` = 0, so `shift_strobe` = 0, `packet_done` = 0, `bit_count` = 0. They take effect in the cycle after the `rst` edge.
- Cycle numbering: cycle n is the cycle following the n-th rising edge at which `enable_timer` = 1 was sampled.
  - `clk_cnt` = n for n ≤ `CLKS_PER_BIT`.
- Strobe k (k = 1..`NUM_BITS`) occurs in cycle (k−1)·`CLKS_PER_BIT` + `SAMPLE_POINT`.
- `packet_done` first goes high in cycle (`NUM_BITS`−1)·`CLKS_PER_BIT` + `SAMPLE_POINT` + 1.
- With default parameters:
  - Strobes occur in cycles 10, 20, …, 90.
  - `packet_done` goes high in cycle 91.
- The control unit leaves the data-read phase on `packet_done`. Both counters then clear on the first edge with `enable_timer` = 0.
- Enable dropped mid-packet:
  - `shift_strobe` and `packet_done` go low combinationally in the same cycle.
  - Both counters read 0 after the next edge.
  - A later enable restarts from cycle 1 with no residual count.
- `rst` asserted mid-packet: it has priority over `enable_timer`, and everything reads 0 in the following cycle.
- `rst` and `enable_timer` both high: the counters stay at 0 and the timer starts counting only on the first edge after `rst` deasserts.
- Edge case `SAMPLE_POINT` = `CLKS_PER_BIT`: the strobe coincides with the wrap cycle. That is legal, and there is exactly one strobe per period.
- Edge case `SAMPLE_POINT` = 1: the strobe lands in the first cycle of each period.

## Test plan
- Reset: drive `rst` = 1 for 2 cycles while `enable_timer` = 1 → all outputs 0. After release, the first strobe comes exactly 10 cycles later.
- Full packet, default parameters: hold `enable_timer` high for 95 cycles.
  - Expect exactly 9 single-cycle strobes, in cycles 10, 20, …, 90.
  - `bit_count` steps 0→9.
  - `packet_done` is 1 from cycle 91 and no strobe occurs after cycle 90.
- Handoff: deassert `enable_timer` in cycle 92 → `packet_done` = 0 that same cycle; `bit_count` = 0 in cycle 93. Re-enable → the first strobe returns at cycle 10 of the new run.
- Abort: drop `enable_timer` in cycle 47 (`bit_count` = 4) → no strobe in cycle 50. After re-enable, strobes restart at cycle 10 and `bit_count` restarts from 0.
- Reset mid-packet: assert `rst` for 1 cycle at cycle 35 with the enable still high → all outputs 0 in cycle 36. The next strobe follows 10 cycles after `rst` deasserts.
- Parameter sweep, `CLKS_PER_BIT` = 16, `SAMPLE_POINT` = 8, `NUM_BITS` = 3 → strobes in cycles 8, 24, 40; `packet_done` goes high in cycle 41.

Source files
------------

// File: rtl/rx_timer.sv
// rx_timer: bit-period timer for the UART receive path.
// Issues one shift_strobe per bit period while enabled, then holds packet_done.
module rx_timer #(
    parameter int unsigned CLKS_PER_BIT = 10,
    parameter int unsigned SAMPLE_POINT = 10,
    parameter int unsigned NUM_BITS     = 9
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable_timer,
    output logic                          shift_strobe,
    output logic                          packet_done,
    output logic [$clog2(NUM_BITS+1)-1:0] bit_count
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned BW = $clog2(NUM_BITS + 1);

    localparam logic [CW-1:0] CLK_WRAP   = CW'(CLKS_PER_BIT);
    localparam logic [CW-1:0] CLK_SAMPLE = CW'(SAMPLE_POINT);
    localparam logic [BW-1:0] BIT_LAST   = BW'(NUM_BITS);

    logic [CW-1:0] clk_cnt;
    logic [CW-1:0] clk_cnt_next;
    logic [BW-1:0] bit_cnt;
    logic [BW-1:0] bit_cnt_next;
    logic          at_sample;
    logic          bits_left;

    // Outputs decode registered state, gated by the live enable so they
    // drop in the same cycle the control unit releases the timer.
    always_comb begin
        at_sample    = (clk_cnt == CLK_SAMPLE);
        bits_left    = (bit_cnt < BIT_LAST);
        shift_strobe = enable_timer && at_sample && bits_left;
        packet_done  = enable_timer && (bit_cnt == BIT_LAST);
    end

    // Period counter runs 1..CLKS_PER_BIT; it keeps wrapping after the
    // last bit since the strobe is suppressed by bits_left.
    always_comb begin
        clk_cnt_next = clk_cnt;
        if (!enable_timer) begin
            clk_cnt_next = '0;
        end else if (clk_cnt == CLK_WRAP) begin
            clk_cnt_next = CW'(1);
        end else begin
            clk_cnt_next = clk_cnt + CW'(1);
        end
    end

    always_comb begin
        bit_cnt_next = bit_cnt;
        if (!enable_timer) begin
            bit_cnt_next = '0;
        end else if (shift_strobe) begin
            bit_cnt_next = bit_cnt + BW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            clk_cnt <= clk_cnt_next;
            bit_cnt <= bit_cnt_next;
        end
    end

    assign bit_count = bit_cnt;

endmodule

// File: tb/tb_rx_timer.sv
// Self-checking bench for rx_timer: default instance plus a 16/8/3 sweep instance,
// checked every cycle against an arithmetic model and at hand-computed points.
module tb_rx_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en_a = 1'b0;
    logic       en_b = 1'b0;
    logic       strobe_a, done_a;
    logic [3:0] bits_a;
    logic       strobe_b, done_b;
    logic [1:0] bits_b;

    int total  = 0;
    int passed = 0;
    int n_a    = 0;
    int n_b    = 0;
    bit seen_rst = 1'b0;
    int log_q[$];

    always #5 clk = ~clk;

    rx_timer #(.CLKS_PER_BIT(10), .SAMPLE_POINT(10), .NUM_BITS(9)) dut_a (
        .clk(clk), .rst(rst), .enable_timer(en_a),
        .shift_strobe(strobe_a), .packet_done(done_a), .bit_count(bits_a)
    );

    rx_timer #(.CLKS_PER_BIT(16), .SAMPLE_POINT(8), .NUM_BITS(3)) dut_b (
        .clk(clk), .rst(rst), .enable_timer(en_b),
        .shift_strobe(strobe_b), .packet_done(done_b), .bit_count(bits_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Model: n = enabled edges since the run started. Strobe k lands in
    // cycle (k-1)*cpb+sp; bit count is the number of strobes before cycle n.
    function automatic int exp_bits(input int n, input int cpb, input int sp, input int nb);
        int c;
        if (n <= sp) return 0;
        c = (n - sp - 1) / cpb + 1;
        return (c > nb) ? nb : c;
    endfunction

    function automatic int exp_strobe(input int n, input int cpb, input int sp, input int nb);
        if (n < sp) return 0;
        if (((n - sp) % cpb) != 0) return 0;
        return (((n - sp) / cpb) < nb) ? 1 : 0;
    endfunction

    always @(posedge clk) begin
        n_a <= (rst || !en_a) ? 0 : n_a + 1;
        n_b <= (rst || !en_b) ? 0 : n_b + 1;
        if (rst) seen_rst <= 1'b1;
    end

    always @(negedge clk) begin
        if (seen_rst) begin
            chk("strobe_a", int'(strobe_a), en_a ? exp_strobe(n_a, 10, 10, 9) : 0);
            chk("done_a",   int'(done_a),   (en_a && exp_bits(n_a, 10, 10, 9) == 9) ? 1 : 0);
            chk("bits_a",   int'(bits_a),   exp_bits(n_a, 10, 10, 9));
            chk("strobe_b", int'(strobe_b), en_b ? exp_strobe(n_b, 16, 8, 3) : 0);
            chk("done_b",   int'(done_b),   (en_b && exp_bits(n_b, 16, 8, 3) == 3) ? 1 : 0);
            chk("bits_b",   int'(bits_b),   exp_bits(n_b, 16, 8, 3));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs cyc enabled cycles on dut_a, logging the cycle index of each strobe.
    task automatic run_a(input int cyc);
        for (int i = 1; i <= cyc; i++) begin
            tick();
            #1;
            if (strobe_a) log_q.push_back(i);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with enable high.
        rst = 1'b1; en_a = 1'b1;
        tick(); tick();
        #1;
        chk("rst_bits", int'(bits_a), 0);
        chk("rst_strobe", int'(strobe_a), 0);
        chk("rst_done", int'(done_a), 0);
        rst = 1'b0;

        // Full packet, then handoff in cycle 92.
        log_q.delete();
        for (int i = 1; i <= 92; i++) begin
            tick();
            if (i == 92) en_a = 1'b0;
            #1;
            if (strobe_a) log_q.push_back(i);
            if (i == 90) chk("done_c90", int'(done_a), 0);
            if (i == 91) chk("done_c91", int'(done_a), 1);
            if (i == 91) chk("bits_c91", int'(bits_a), 9);
            if (i == 92) chk("done_c92_off", int'(done_a), 0);
        end
        chk("full_nstrobes", log_q.size(), 9);
        foreach (log_q[k]) chk("full_strobe_cycle", log_q[k], 10 * (k + 1));
        tick();
        #1;
        chk("bits_c93", int'(bits_a), 0);

        // Re-enable after handoff.
        en_a = 1'b1;
        log_q.delete();
        run_a(12);
        chk("reen_nstrobes", log_q.size(), 1);
        if (log_q.size() > 0) chk("reen_first", log_q[0], 10);

        // Abort in cycle 47.
        en_a = 1'b0;
        tick();
        en_a = 1'b1;
        log_q.delete();
        run_a(46);
        tick();
        en_a = 1'b0;
        #1;
        chk("abort_bits_c47", int'(bits_a), 4);
        chk("abort_nstrobes", log_q.size(), 4);
        log_q.delete();
        for (int i = 48; i <= 52; i++) begin
            tick();
            #1;
            if (strobe_a) log_q.push_back(i);
        end
        chk("abort_no_strobe", log_q.size(), 0);
        en_a = 1'b1;
        log_q.delete();
        tick();
        #1;
        chk("abort_restart_bits", int'(bits_a), 0);
        log_q.push_back(0);
        log_q.delete();
        for (int i = 2; i <= 12; i++) begin
            tick();
            #1;
            if (strobe_a) log_q.push_back(i);
        end
        chk("abort_restart_n", log_q.size(), 1);
        if (log_q.size() > 0) chk("abort_restart_first", log_q[0], 10);

        // Reset at cycle 35 with enable still high.
        en_a = 1'b0;
        tick();
        en_a = 1'b1;
        run_a(34);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rstmid_bits", int'(bits_a), 0);
        chk("rstmid_strobe", int'(strobe_a), 0);
        log_q.delete();
        run_a(12);
        chk("rstmid_n", log_q.size(), 1);
        if (log_q.size() > 0) chk("rstmid_first", log_q[0], 10);

        // Parameter sweep on dut_b.
        en_a = 1'b0;
        en_b = 1'b1;
        log_q.delete();
        for (int i = 1; i <= 45; i++) begin
            tick();
            #1;
            if (strobe_b) log_q.push_back(i);
            if (i == 40) chk("sweep_done_c40", int'(done_b), 0);
            if (i == 41) chk("sweep_done_c41", int'(done_b), 1);
        end
        chk("sweep_n", log_q.size(), 3);
        if (log_q.size() == 3) begin
            chk("sweep_s1", log_q[0], 8);
            chk("sweep_s2", log_q[1], 24);
            chk("sweep_s3", log_q[2], 40);
        end
        en_b = 1'b0;
        tick();
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
